alu_exec_stage: RTL and testbench
=================================

# alu_exec_stage

Pipelined execute stage that wraps the combinational `ALU`. It accepts decoded operations from the issue/decode stage over a valid/ready handshake and registers them into an EX register that drives the `ALU`. It captures `ALU_result` and `zero` into a WB register and presents them downstream to the writeback/branch logic over a second valid/ready handshake. Full throughput (one operation per cycle) when downstream is ready. Fixed 2-cycle latency. In-order, no reordering.

## Interface
- `DATA_WIDTH`, 32, operand/result width (the `ALU` is 32-bit; other values are unsupported)
- `TAG_WIDTH`, 5, opaque destination tag carried alongside each operation
- `CNT_WIDTH`, 32, width of the completed-operation counter
- `clock`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low; clears all state immediately
- `in_valid`  in  1  upstream offers an operation
- `in_ready`  out  1  stage can accept this cycle
- `ALU_Control`  in  4  operation code, passed unchanged to `ALU`
- `operand_A`, `operand_B`  in  DATA_WIDTH  operands
- `in_tag`  in  TAG_WIDTH  destination tag
- `out_valid`  out  1  result available
- `out_ready`  in  1  downstream accepts result
- `ALU_result`  out  DATA_WIDTH  registered result
- `zero`  out  1  registered zero flag (1 when the result is all zeros)
- `out_tag`  out  TAG_WIDTH  tag of the presented result
- `ops_completed`  out  CNT_WIDTH  count of output handshakes

## Operation
- Two register slots:
  - EX slot: `ex_valid`, control, operands, tag.
  - WB slot: `wb_valid`, result, zero, tag.
- The `ALU` is instantiated between the EX and WB slots and is driven only from EX registers, never from raw inputs.
- `ALU_Control` codes:
  - `0000` AND
  - `0001` OR
  - `0010` ADD (wraps mod 2^32)
  - `0110` SUB (wraps)
  - `0111` SLT (signed; result 1 or 0)
  - `1100` NOR
  - any other code gives result 0, zero=1
- Flow control:
  - `wb_adv = !wb_valid || out_ready`
  - `in_ready = !ex_valid || wb_adv`. This is combinational from `out_ready`; no other combinational path from input to output.
- EX load on edge when `in_valid && in_ready`. If `ex_valid && wb_adv` and there is no new input, EX clears to empty.
- WB load on edge when `wb_adv`: `wb_valid <= ex_valid`, capturing the `ALU` outputs and tag. On a bubble, WB data may hold its old value, but `wb_valid` must be 0.
- While `out_valid && !out_ready`, WB and EX hold. `ALU_result`, `zero` and `out_tag` must stay stable until the handshake.
- `ops_completed` increments on each `out_valid && out_ready` edge and wraps from all-ones to 0.
- Data outputs reflect the WB registers; `out_valid = wb_valid`.

## Timing
- Reset asserted: `out_valid`=0, `ALU_result`=0, `zero`=0, `out_tag`=0, `ops_completed`=0, EX cleared.
  - `in_ready`=1 while in reset, but inputs are ignored until reset deasserts.
- Reset mid-operation discards every in-flight operation; none reappears after reset.
- Latency: operation accepted at edge k → loaded into EX at k → in WB at k+1 → `out_valid`=1 in the cycle following edge k+1.
- Back-to-back: with `out_ready`=1 permanently, one result per cycle in acceptance order.
- Full condition: both slots valid and `out_ready`=0 → `in_ready`=0.
- Simultaneous output handshake and input accept when full is legal: all slots shift and nothing is lost or duplicated.
- At most 2 operations in flight.

## Test plan
- Reset then single ops, `out_ready`=1. Each result appears 2 cycles after accept with matching tag:
  - A=7, B=0xB, AND → 3, zero=0
  - A=2, B=4, OR → 6
  - A=0xA, B=4, SUB → 6
  - A=2, B=4, SLT → 1
  - A=2, B=4, NOR → 0xFFFFFFF9
- Zero flag and wrap:
  - A=5, B=5, SUB → 0, zero=1
  - A=0xFFFFFFFF, B=1, ADD → 0, zero=1
  - A=0x80000000, B=1, SLT → 1
- Backpressure: stream 4 ops with tags 1..4 while `out_ready`=0.
  - `in_ready` drops after 2 accepts, with out_tag=1 held stable.
  - Releasing `out_ready` drains tags 1,2,3,4 in order with no loss or duplication.
- Streaming: 16 consecutive ops with `out_ready`=1 → 16 results on 16 consecutive cycles, `ops_completed`=16.
- Reset mid-flight: accept 2 ops, assert reset for 1 cycle → `out_valid`=0 and `ops_completed`=0. No stale result appears after deassert, and the next op completes normally.
- Illegal code `1111` with A=3, B=3 → result 0, zero=1; the pipeline continues unaffected.

Source files
------------

// File: rtl/alu_exec_stage_if.sv
// Handshake bundle between issue/decode, the execute stage, and writeback/branch logic.
// The slave modport is the execute stage's view; master is the surrounding pipeline's view.
interface alu_exec_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 5,
    parameter int CNT_WIDTH  = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [3:0]            ALU_Control;
    logic [DATA_WIDTH-1:0] operand_A;
    logic [DATA_WIDTH-1:0] operand_B;
    logic [TAG_WIDTH-1:0]  in_tag;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] ALU_result;
    logic                  zero;
    logic [TAG_WIDTH-1:0]  out_tag;
    logic [CNT_WIDTH-1:0]  ops_completed;

    modport slave (
        input  in_valid, ALU_Control, operand_A, operand_B, in_tag, out_ready,
        output in_ready, out_valid, ALU_result, zero, out_tag, ops_completed
    );

    modport master (
        output in_valid, ALU_Control, operand_A, operand_B, in_tag, out_ready,
        input  in_ready, out_valid, ALU_result, zero, out_tag, ops_completed
    );
endinterface

// File: rtl/alu_exec_stage.sv
// Two-slot execute stage: EX register feeds the ALU, WB register holds result/zero/tag
// for the writeback handshake. Fixed 2-cycle latency, full throughput, in order.
module alu_exec_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 5,
    parameter int CNT_WIDTH  = 32
) (
    input logic             clock,
    input logic             reset,
    alu_exec_stage_if.slave bus
);
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    logic                  ex_valid_q, ex_valid_d;
    logic [3:0]            ex_ctrl_q, ex_ctrl_d;
    logic [DATA_WIDTH-1:0] ex_a_q, ex_a_d;
    logic [DATA_WIDTH-1:0] ex_b_q, ex_b_d;
    logic [TAG_WIDTH-1:0]  ex_tag_q, ex_tag_d;

    logic                  wb_valid_q, wb_valid_d;
    logic [DATA_WIDTH-1:0] wb_res_q, wb_res_d;
    logic                  wb_zero_q, wb_zero_d;
    logic [TAG_WIDTH-1:0]  wb_tag_q, wb_tag_d;

    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic                  wb_adv;
    logic                  in_rdy;
    logic                  accept;
    logic [DATA_WIDTH-1:0] alu_res;
    logic                  alu_zero;

    // Undefined control codes yield 0, so the zero flag reads 1 for them.
    function automatic logic [DATA_WIDTH-1:0] alu_f(input logic [3:0]            ctrl,
                                                    input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b);
        logic signed [DATA_WIDTH-1:0] sa;
        logic signed [DATA_WIDTH-1:0] sb;
        sa = a;
        sb = b;
        case (ctrl)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_SLT:  return (sa < sb) ? DATA_WIDTH'(1) : '0;
            OP_NOR:  return ~(a | b);
            default: return '0;
        endcase
    endfunction

    always_comb begin
        alu_res  = alu_f(ex_ctrl_q, ex_a_q, ex_b_q);
        alu_zero = (alu_res == '0);
        wb_adv   = !wb_valid_q || bus.out_ready;
        in_rdy   = !ex_valid_q || wb_adv;
        accept   = bus.in_valid && in_rdy;
    end

    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_ctrl_d  = ex_ctrl_q;
        ex_a_d     = ex_a_q;
        ex_b_d     = ex_b_q;
        ex_tag_d   = ex_tag_q;
        wb_valid_d = wb_valid_q;
        wb_res_d   = wb_res_q;
        wb_zero_d  = wb_zero_q;
        wb_tag_d   = wb_tag_q;
        cnt_d      = cnt_q;

        // EX slot: load on accept, otherwise drain when WB takes its contents
        if (accept) begin
            ex_valid_d = 1'b1;
            ex_ctrl_d  = bus.ALU_Control;
            ex_a_d     = bus.operand_A;
            ex_b_d     = bus.operand_B;
            ex_tag_d   = bus.in_tag;
        end else if (wb_adv) begin
            ex_valid_d = 1'b0;
        end

        // WB slot: a bubble only clears valid, data keeps its last value
        if (wb_adv) begin
            wb_valid_d = ex_valid_q;
            if (ex_valid_q) begin
                wb_res_d  = alu_res;
                wb_zero_d = alu_zero;
                wb_tag_d  = ex_tag_q;
            end
        end

        if (wb_valid_q && bus.out_ready) begin
            cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= '0;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            ex_tag_q   <= '0;
            wb_valid_q <= 1'b0;
            wb_res_q   <= '0;
            wb_zero_q  <= 1'b0;
            wb_tag_q   <= '0;
            cnt_q      <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_ctrl_q  <= ex_ctrl_d;
            ex_a_q     <= ex_a_d;
            ex_b_q     <= ex_b_d;
            ex_tag_q   <= ex_tag_d;
            wb_valid_q <= wb_valid_d;
            wb_res_q   <= wb_res_d;
            wb_zero_q  <= wb_zero_d;
            wb_tag_q   <= wb_tag_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.in_ready      = in_rdy;
    assign bus.out_valid     = wb_valid_q;
    assign bus.ALU_result    = wb_res_q;
    assign bus.zero          = wb_zero_q;
    assign bus.out_tag       = wb_tag_q;
    assign bus.ops_completed = cnt_q;
endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: single ops, zero/wrap, backpressure,
// streaming, mid-flight reset and an undefined control code.
module tb_alu_exec_stage;
    localparam int DW = 32;
    localparam int TW = 5;
    localparam int CW = 32;

    localparam logic [3:0] C_AND = 4'b0000;
    localparam logic [3:0] C_OR  = 4'b0001;
    localparam logic [3:0] C_ADD = 4'b0010;
    localparam logic [3:0] C_SUB = 4'b0110;
    localparam logic [3:0] C_SLT = 4'b0111;
    localparam logic [3:0] C_NOR = 4'b1100;
    localparam logic [3:0] C_BAD = 4'b1111;

    logic clock = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clock = ~clock;

    alu_exec_stage_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .CNT_WIDTH(CW)) bus ();

    alu_exec_stage #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .CNT_WIDTH(CW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] t);
        bus.ALU_Control = c;
        bus.operand_A   = a;
        bus.operand_B   = b;
        bus.in_tag      = t;
        bus.in_valid    = 1'b1;
    endtask

    // One op through an idle pipeline with out_ready=1: visible after the second edge.
    task automatic single(input string nm, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] t,
                          input logic [31:0] er, input logic ez);
        drive(c, a, b, t);
        chk({nm, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk({nm, "_lat1_valid"}, 32'(bus.out_valid), 32'd0);
        tick();
        chk({nm, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({nm, "_result"}, bus.ALU_result, er);
        chk({nm, "_zero"}, 32'(bus.zero), 32'(ez));
        chk({nm, "_tag"}, 32'(bus.out_tag), 32'(t));
        tick();
        chk({nm, "_drained"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset           = 1'b0;
        bus.out_ready   = 1'b1;
        drive(C_ADD, 32'd1, 32'd1, 5'd7);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_result", bus.ALU_result, 32'd0);
        chk("rst_zero", 32'(bus.zero), 32'd0);
        chk("rst_tag", 32'(bus.out_tag), 32'd0);
        chk("rst_cnt", bus.ops_completed, 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        tick();
        chk("rst_ignores_input", 32'(bus.out_valid), 32'd0);
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        tick();
        chk("post_rst_idle", 32'(bus.out_valid), 32'd0);

        single("and", C_AND, 32'h7, 32'hB, 5'd1, 32'h3, 1'b0);
        single("or", C_OR, 32'd2, 32'd4, 5'd2, 32'h6, 1'b0);
        single("sub", C_SUB, 32'hA, 32'd4, 5'd3, 32'h6, 1'b0);
        single("slt", C_SLT, 32'd2, 32'd4, 5'd4, 32'h1, 1'b0);
        single("nor", C_NOR, 32'd2, 32'd4, 5'd5, 32'hFFFF_FFF9, 1'b0);
        single("sub_zero", C_SUB, 32'd5, 32'd5, 5'd6, 32'h0, 1'b1);
        single("add_wrap", C_ADD, 32'hFFFF_FFFF, 32'd1, 5'd7, 32'h0, 1'b1);
        single("slt_neg", C_SLT, 32'h8000_0000, 32'd1, 5'd8, 32'h1, 1'b0);
        chk("cnt_after_singles", bus.ops_completed, 32'd8);

        // Backpressure: two accepts fill both slots, third is refused.
        bus.out_ready = 1'b0;
        drive(C_ADD, 32'd1, 32'd10, 5'd1);
        chk("bp_rdy1", 32'(bus.in_ready), 32'd1);
        tick();
        drive(C_ADD, 32'd2, 32'd10, 5'd2);
        chk("bp_rdy2", 32'(bus.in_ready), 32'd1);
        tick();
        drive(C_ADD, 32'd3, 32'd10, 5'd3);
        chk("bp_full_rdy", 32'(bus.in_ready), 32'd0);
        chk("bp_full_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_full_tag", 32'(bus.out_tag), 32'd1);
        tick();
        chk("bp_hold_rdy", 32'(bus.in_ready), 32'd0);
        chk("bp_hold_tag", 32'(bus.out_tag), 32'd1);
        chk("bp_hold_result", bus.ALU_result, 32'd11);
        tick();
        chk("bp_hold2_tag", 32'(bus.out_tag), 32'd1);
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_rdy", 32'(bus.in_ready), 32'd1);
        tick();
        chk("bp_drain_tag2", 32'(bus.out_tag), 32'd2);
        chk("bp_drain_res2", bus.ALU_result, 32'd12);
        drive(C_ADD, 32'd4, 32'd10, 5'd4);
        chk("bp_rdy4", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("bp_drain_tag3", 32'(bus.out_tag), 32'd3);
        chk("bp_drain_res3", bus.ALU_result, 32'd13);
        tick();
        chk("bp_drain_tag4", 32'(bus.out_tag), 32'd4);
        chk("bp_drain_res4", bus.ALU_result, 32'd14);
        chk("bp_drain_valid4", 32'(bus.out_valid), 32'd1);
        tick();
        chk("bp_empty", 32'(bus.out_valid), 32'd0);
        chk("bp_cnt", bus.ops_completed, 32'd12);

        // Reset with two ops in flight.
        drive(C_AND, 32'hF, 32'hF, 5'd20);
        tick();
        drive(C_OR, 32'h1, 32'h2, 5'd21);
        tick();
        bus.in_valid = 1'b0;
        chk("mid_pre_valid", 32'(bus.out_valid), 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_cnt", bus.ops_completed, 32'd0);
        chk("mid_rst_result", bus.ALU_result, 32'd0);
        chk("mid_rst_tag", 32'(bus.out_tag), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        chk("mid_no_stale1", 32'(bus.out_valid), 32'd0);
        tick();
        chk("mid_no_stale2", 32'(bus.out_valid), 32'd0);
        chk("mid_cnt_hold", bus.ops_completed, 32'd0);

        // Streaming: 16 ops, one result per cycle from the second edge on.
        for (int c = 0; c <= 16; c++) begin
            if (c < 16) begin
                drive(C_ADD, 32'(c), 32'd100, 5'(c));
                chk("stream_rdy", 32'(bus.in_ready), 32'd1);
            end else begin
                bus.in_valid = 1'b0;
            end
            tick();
            if (c >= 1) begin
                chk("stream_valid", 32'(bus.out_valid), 32'd1);
                chk("stream_result", bus.ALU_result, 32'(c - 1 + 100));
                chk("stream_tag", 32'(bus.out_tag), 32'(5'(c - 1)));
            end else begin
                chk("stream_first_lat", 32'(bus.out_valid), 32'd0);
            end
        end
        tick();
        chk("stream_done_valid", 32'(bus.out_valid), 32'd0);
        chk("stream_cnt", bus.ops_completed, 32'd16);

        single("illegal", C_BAD, 32'd3, 32'd3, 5'd9, 32'h0, 1'b1);
        single("post_illegal", C_ADD, 32'h10, 32'h20, 5'd10, 32'h30, 1'b0);
        chk("final_cnt", bus.ops_completed, 32'd18);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
